// File: rtl/uop_pkg.sv
// Shared micro-op definitions: op codes, issue FSM states and per-op latency lookup.
package uop_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_IMUL = 4'd9,
    OP_DIV  = 4'd10,
    OP_IDIV = 4'd11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 8;
  localparam int LAT_W   = 4;

  // Codes 12..15 are unassigned and fall through to single-cycle latency.
  function automatic logic [LAT_W-1:0] op_latency(op_t op);
    case (op)
      OP_MUL, OP_IMUL: return LAT_W'(LAT_MUL);
      OP_DIV, OP_IDIV: return LAT_W'(LAT_DIV);
      default:         return LAT_W'(1);
    endcase
  endfunction

  function automatic logic is_div(op_t op);
    return (op == OP_DIV) || (op == OP_IDIV);
  endfunction

endpackage

// File: rtl/uop_req_fifo.sv
// In-order request FIFO; a push into a full FIFO is dropped even when a pop happens that cycle.
module uop_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]              cnt_q, cnt_d;
  logic                     do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uop_issue_ctrl.sv
// Queues micro-ops, issues one at a time to an external execution unit, waits the op's
// fixed latency, then holds the captured result until the consumer takes it.
module uop_issue_ctrl
  import uop_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int TW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  op_t                  req_op,
  input  logic [W-1:0]         req_a,
  input  logic [W-1:0]         req_b,
  input  logic [$clog2(W)-1:0] req_shamt,
  input  logic [TW-1:0]        req_tag,
  output op_t                  ex_op,
  output logic [W-1:0]         ex_a,
  output logic [W-1:0]         ex_b,
  output logic [$clog2(W)-1:0] ex_shamt,
  input  logic [W-1:0]         ex_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_y,
  output logic [TW-1:0]        rsp_tag,
  output logic                 rsp_dz,
  output logic                 busy
);
  localparam int SW = $clog2(W);
  localparam int OW = $bits(op_t);
  localparam int DW = OW + 2*W + SW + TW;

  logic [DW-1:0] f_wdata, f_rdata;
  logic          f_full, f_empty, f_pop;

  logic [OW-1:0] h_op_bits;
  logic [W-1:0]  h_a, h_b;
  logic [SW-1:0] h_shamt;
  logic [TW-1:0] h_tag;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  op_t              ex_op_q, ex_op_d;
  logic [W-1:0]     ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [SW-1:0]    ex_shamt_q, ex_shamt_d;
  logic [TW-1:0]    ex_tag_q, ex_tag_d;
  logic [W-1:0]     rsp_y_q, rsp_y_d;
  logic [TW-1:0]    rsp_tag_q, rsp_tag_d;
  logic             rsp_dz_q, rsp_dz_d;

  assign f_wdata = {req_op, req_a, req_b, req_shamt, req_tag};
  assign {h_op_bits, h_a, h_b, h_shamt, h_tag} = f_rdata;

  uop_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_shamt_d = ex_shamt_q;
    ex_tag_d   = ex_tag_q;
    rsp_y_d    = rsp_y_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_dz_d   = rsp_dz_q;
    f_pop      = 1'b0;
    case (state_q)
      ST_IDLE: f_pop = !f_empty;
      ST_EXEC: begin
        if (cnt_q == LAT_W'(1)) begin
          rsp_y_d   = ex_y;
          rsp_tag_d = ex_tag_q;
          rsp_dz_d  = is_div(ex_op_q) && (ex_b_q == '0);
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!f_empty) f_pop = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop always starts a fresh op, whether from IDLE or straight out of RESP.
    if (f_pop) begin
      state_d    = ST_EXEC;
      ex_op_d    = op_t'(h_op_bits);
      ex_a_d     = h_a;
      ex_b_d     = h_b;
      ex_shamt_d = h_shamt;
      ex_tag_d   = h_tag;
      cnt_d      = op_latency(op_t'(h_op_bits));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ex_op_q    <= OP_NOP;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_shamt_q <= '0;
      ex_tag_q   <= '0;
      rsp_y_q    <= '0;
      rsp_tag_q  <= '0;
      rsp_dz_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_op_q    <= ex_op_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_shamt_q <= ex_shamt_d;
      ex_tag_q   <= ex_tag_d;
      rsp_y_q    <= rsp_y_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  assign req_ready = !f_full;
  assign ex_op     = ex_op_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_shamt  = ex_shamt_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_y     = rsp_y_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_dz    = rsp_dz_q;
  assign busy      = !f_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uop_issue_ctrl.sv
// Random + directed bench for uop_issue_ctrl against a queue-based transaction model.
module tb_uop_issue_ctrl;
  import uop_pkg::*;

  localparam int W = 64, DEPTH = 4, TW = 4, SW = $clog2(W);

  typedef struct packed {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] sh;
    logic [TW-1:0] tag;
  } item_t;

  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_dz, busy;
  op_t  req_op = OP_NOP, ex_op;
  logic [W-1:0]  req_a = '0, req_b = '0, ex_a, ex_b, ex_y, rsp_y;
  logic [SW-1:0] req_shamt = '0, ex_shamt;
  logic [TW-1:0] req_tag = '0, rsp_tag;

  always #5 clk = ~clk;

  uop_issue_ctrl #(.W(W), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_tag(req_tag),
    .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_y(ex_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_tag(rsp_tag),
    .rsp_dz(rsp_dz), .busy(busy)
  );

  // Behavioural execution unit; division by zero yields 0.
  function automatic logic [W-1:0] alu_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                           logic [SW-1:0] sh);
    case (op_t'(op))
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << sh;
      OP_SHR:  return a >> sh;
      OP_MUL:  return a * b;
      OP_IMUL: return W'($signed(a) * $signed(b));
      OP_DIV:  return (b == '0) ? '0 : a / b;
      OP_IDIV: return (b == '0) ? '0 : W'($signed(a) / $signed(b));
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(logic [3:0] op);
    if (op == 4'd8 || op == 4'd9)  return 3;
    if (op == 4'd10 || op == 4'd11) return 8;
    return 1;
  endfunction

  assign ex_y = alu_ref(4'(ex_op), ex_a, ex_b, ex_shamt);

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Model: queue of waiting ops, phase 0=idle 1=executing 2=responding.
  item_t         mq[$];
  item_t         cur;
  int            ph, rem;
  logic [W-1:0]  e_y;
  logic [TW-1:0] e_tag;
  logic          e_dz;
  int            tag_ctr = 0;

  task automatic mdl_reset();
    mq.delete();
    cur = '0; ph = 0; rem = 0; e_y = '0; e_tag = '0; e_dz = 1'b0;
  endtask

  task automatic mdl_pop();
    cur = mq.pop_front();
    ph  = 1;
    rem = lat_of(cur.op);
  endtask

  task automatic mdl_step();
    bit    pushing = req_valid && (mq.size() < DEPTH);
    item_t in_it   = {4'(req_op), req_a, req_b, req_shamt, req_tag};
    case (ph)
      0: if (mq.size() > 0) mdl_pop();
      1: begin
        if (rem == 1) begin
          ph    = 2;
          e_y   = alu_ref(cur.op, cur.a, cur.b, cur.sh);
          e_tag = cur.tag;
          e_dz  = (cur.op == 4'd10 || cur.op == 4'd11) && (cur.b == '0);
        end else rem--;
      end
      default: if (rsp_ready) begin
        if (mq.size() > 0) mdl_pop();
        else ph = 0;
      end
    endcase
    if (pushing) mq.push_back(in_it);
  endtask

  task automatic check_all();
    chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
    chk("rsp_valid", 64'(rsp_valid), 64'(ph == 2));
    chk("busy",      64'(busy),      64'(mq.size() > 0 || ph != 0));
    chk("ex_op",     64'(ex_op),     64'(cur.op));
    chk("ex_a",      ex_a,           cur.a);
    chk("ex_b",      ex_b,           cur.b);
    chk("ex_shamt",  64'(ex_shamt),  64'(cur.sh));
    chk("rsp_y",     rsp_y,          e_y);
    chk("rsp_tag",   64'(rsp_tag),   64'(e_tag));
    chk("rsp_dz",    64'(rsp_dz),    64'(e_dz));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) mdl_step();
    else mdl_reset();
    #1;
    check_all();
  endtask

  task automatic drive(input item_t it);
    req_op = op_t'(it.op); req_a = it.a; req_b = it.b;
    req_shamt = it.sh; req_tag = it.tag; req_valid = 1'b1;
  endtask

  function automatic item_t mk(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [TW-1:0] tag);
    item_t it;
    it.op = op; it.a = a; it.b = b; it.sh = '0; it.tag = tag;
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.op  = 4'($urandom_range(15));
    it.a   = {32'($urandom), 32'($urandom)};
    if (it.a == {1'b1, {(W-1){1'b0}}}) it.a = 64'd1;
    it.b   = ($urandom_range(3) == 0) ? '0 : 64'($urandom);
    it.sh  = SW'($urandom_range(W-1));
    it.tag = TW'(tag_ctr);
    tag_ctr++;
    return it;
  endfunction

  task automatic push_wait(input item_t it);
    bit acc;
    int g = 0;
    drive(it);
    do begin
      acc = req_ready;
      cycle();
      g++;
    end while (!acc && g < 200);
    req_valid = 1'b0;
    chk("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_rsp(input int bound);
    int g = 0;
    while (!rsp_valid && g < bound) begin cycle(); g++; end
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  // Random traffic: req_valid is held with a stable item until accepted.
  task automatic run_ops(input int n, input int p_valid, input int p_ready);
    int  sent = 0, g = 0;
    bit  acc;
    while ((sent < n || req_valid || mq.size() > 0 || ph != 0) && g < 4000) begin
      if (!req_valid && sent < n && $urandom_range(99) < p_valid) drive(rand_item());
      rsp_ready = ($urandom_range(99) < p_ready);
      acc = req_valid && req_ready;
      cycle();
      if (acc) begin sent++; req_valid = 1'b0; end
      g++;
    end
    chk("run_timeout", 64'(g < 4000), 64'd1);
  endtask

  initial begin
    mdl_reset();
    cycle(); cycle();
    rst_n = 1'b1;
    #2;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // ADD 5+7, tag 3: single-cycle op
    rsp_ready = 1'b1;
    push_wait(mk(4'd1, 64'd5, 64'd7, 4'd3));
    cycle();
    chk("add_early", 64'(rsp_valid), 64'd0);
    cycle();
    chk("add_vld", 64'(rsp_valid), 64'd1);
    chk("add_y",   rsp_y, 64'd12);
    chk("add_tag", 64'(rsp_tag), 64'd3);
    cycle();

    // MUL 6*7: three-cycle latency
    push_wait(mk(4'd8, 64'd6, 64'd7, 4'd4));
    cycle(); cycle(); cycle();
    chk("mul_early", 64'(rsp_valid), 64'd0);
    cycle();
    chk("mul_vld", 64'(rsp_valid), 64'd1);
    chk("mul_y",   rsp_y, 64'd42);
    cycle();

    // DIV by zero flags rsp_dz
    push_wait(mk(4'd10, 64'd9, 64'd0, 4'd5));
    wait_rsp(20);
    chk("div_dz", 64'(rsp_dz), 64'd1);
    chk("div_y",  rsp_y, 64'd0);
    cycle();

    // Fill with consumer stalled: one in RESP plus DEPTH queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_wait(mk(4'd1, 64'(i), 64'd100, TW'(i + 8)));
    cycle();
    chk("full_ready", 64'(req_ready), 64'd0);
    // Push attempt while full and popping the same cycle must be refused
    drive(mk(4'd2, 64'd50, 64'd8, 4'd13));
    rsp_ready = 1'b1;
    cycle();
    chk("full_pop_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b0;
    push_wait(mk(4'd2, 64'd50, 64'd8, 4'd13));
    run_ops(0, 0, 40);

    // Random traffic with random back-pressure
    tag_ctr = 0;
    run_ops(24, 60, 50);
    run_ops(12, 100, 100);

    // Reset during a DIV with three ops queued
    rsp_ready = 1'b1;
    push_wait(mk(4'd10, 64'd100, 64'd7, 4'd1));
    push_wait(mk(4'd1, 64'd1, 64'd2, 4'd2));
    push_wait(mk(4'd8, 64'd3, 64'd4, 4'd3));
    push_wait(mk(4'd5, 64'd5, 64'd6, 4'd4));
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_vld",  64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_exop", 64'(ex_op), 64'(OP_NOP));
    check_all();
    cycle(); cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
